mult_booth_ctrl: RTL and testbench
==================================

Name: mult_booth_ctrl

Overview:
- Control FSM for the radix-2 Booth multiplier datapath `mult_with_no_sm`.
- Drives the `mult_control_t` bundle and consumes the datapath's `Q_LSB` pair {LQ[0], Q_1}.
- Sequences load, N add/sub-evaluate/shift iterations, and completion.
- Exposes a start/ready/done handshake to the surrounding system.

Parameters:
- N, 8, operand width; must match the datapath's N; number of Booth iterations.
- CNT_W, $clog2(N+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a multiplication; sampled only while ready=1.
- Q_LSB  input  2  {LQ[0], Q_1} from the datapath.
- mult_control  output  mult_control_t  {load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub} to the datapath.
- ready  output  1  FSM idle; start will be accepted.
- busy  output  1  operation in progress (LOAD through DONE).
- done  output  1  one-cycle pulse; product valid on datapath Y this cycle.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, counter=0, all mult_control fields 0, ready=1, busy=0, done=0. Applies immediately, including mid-operation; the datapath result is then undefined.
- States: IDLE, LOAD, EVAL, SHIFT, DONE. All outputs are Moore-decoded from state, except load_add and add_sub in EVAL, which decode Q_LSB combinationally.
- IDLE:
  - ready=1, all controls 0.
  - start=1 -> LOAD, counter cleared.
  - start is ignored in every other state (no queuing).
- LOAD: load_A=1, load_B=1, all other controls 0; busy=1; -> EVAL.
- EVAL: Q_LSB decode, then -> SHIFT:
  - 01: load_add=1, add_sub=1 (add).
  - 10: load_add=1, add_sub=0 (subtract).
  - 00/11: load_add=0, add_sub=0.
- SHIFT: shift_HQ_LQ_Q_1=1, other controls 0; counter+1.
  - If counter+1 == N -> DONE.
  - Else -> EVAL.
- DONE: done=1, busy=1, ready=0, controls 0; -> IDLE unconditionally.
- Exclusivity: shift_HQ_LQ_Q_1 is never asserted in the same cycle as load_A, load_B or load_add.
- Latency: start accepted at edge 0; LOAD in cycle 1; EVAL/SHIFT in cycles 2..2N+1; DONE in cycle 2N+2 (cycle 18 for N=8). Back-to-back throughput is one op per 2N+3 cycles.
- start held high continuously: the next op is accepted in the IDLE cycle following DONE.
- Unreachable state encodings -> IDLE with all outputs 0.
- Counter never exceeds N.
- Clearing of HQ and Q_1 between operations is outside this block's scope.

Optional Feature:
- Macro: MULT_EARLY_SKIP_EN.
- Defined: in EVAL, Q_LSB=00 or 11 asserts shift_HQ_LQ_Q_1 in that same cycle and increments the counter, merging EVAL and SHIFT.
  - Next state is EVAL, or DONE on the final iteration.
  - Latency is variable: N+2 to 2N+2 cycles to DONE.
- Undefined: fixed 2N+2 latency as above.

Decomposition:
- Package mult_pkg holds:
  - mult_control_t, relocated from the datapath file; both datapath and controller import it.
  - State enum mult_state_e.
  - Booth decode localparams BOOTH_NOP0=2'b00, BOOTH_ADD=2'b01, BOOTH_SUB=2'b10, BOOTH_NOP1=2'b11.
- No sub-module inside the controller.
- A separate top, mult_booth_top, instantiates mult_booth_ctrl plus mult_with_no_sm; it is not part of this block.

Test Plan:
- Reset: rst_n=0 from t=0 -> all mult_control fields 0, ready=1, busy=0, done=0.
- N=8, single start pulse, Q_LSB forced 00 -> LOAD in cycle 1 with load_A=load_B=1; exactly 8 shift pulses in cycles 3,5,...,17; load_add never set; done=1 only in cycle 18; ready=1 in cycle 19.
- Q_LSB forced 01 -> every EVAL cycle (2,4,...,16) has load_add=1, add_sub=1. Q_LSB forced 10 -> load_add=1, add_sub=0. No cycle ever has load_add and shift both high.
- start held high for 40 cycles -> LOAD in cycles 1 and 20 only; start pulses during cycles 2..18 produce no extra LOAD.
- rst_n dropped mid-cycle 7 -> controls go 0 immediately (async, before the next edge). After release, ready=1, and a new start produces LOAD one cycle later.
- MULT_EARLY_SKIP_EN defined, Q_LSB forced 00 -> shift high in cycles 2..9, done in cycle 10. With Q_LSB forced 01 -> done in cycle 18.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types for the radix-2 Booth multiplier: control bundle, controller
// state encoding and Booth pair decode values.
package mult_pkg;

    typedef struct packed {
        logic load_A;
        logic load_B;
        logic load_add;
        logic shift_HQ_LQ_Q_1;
        logic add_sub;
    } mult_control_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } mult_state_e;

    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

    localparam mult_control_t CTRL_NONE = '0;

    // True when the {LQ[0], Q_1} pair calls for an add or subtract.
    function automatic logic booth_is_op(input logic [1:0] q_lsb);
        return (q_lsb == BOOTH_ADD) || (q_lsb == BOOTH_SUB);
    endfunction

endpackage

// File: rtl/mult_booth_ctrl.sv
// Radix-2 Booth controller: load, N evaluate/shift iterations, done pulse.
// Build option MULT_EARLY_SKIP_EN merges EVAL and SHIFT for 00/11 pairs.
module mult_booth_ctrl
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    Q_LSB,
    output mult_control_t mult_control,
    output logic          ready,
    output logic          busy,
    output logic          done
);

    localparam int CNT_W = $clog2(N + 1);

    mult_state_e        r_state;
    logic [CNT_W-1:0]   r_cnt;

    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_last;
    logic               w_is_op;
    mult_control_t      w_ctrl;
    logic               w_ready;
    logic               w_busy;
    logic               w_done;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_last    = (w_cnt_inc == CNT_W'(N));
    assign w_is_op   = booth_is_op(Q_LSB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_cnt   <= '0;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_EVAL;
                end
                ST_EVAL: begin
`ifdef MULT_EARLY_SKIP_EN
                    if (!w_is_op) begin
                        r_cnt   <= w_cnt_inc;
                        r_state <= w_last ? ST_DONE : ST_EVAL;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
`else
                    r_state <= ST_SHIFT;
`endif
                end
                ST_SHIFT: begin
                    r_cnt   <= w_cnt_inc;
                    r_state <= w_last ? ST_DONE : ST_EVAL;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Moore decode; only the EVAL add/sub strobes look at Q_LSB directly.
    always_comb begin
        w_ctrl  = CTRL_NONE;
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
            end
            ST_LOAD: begin
                w_busy        = 1'b1;
                w_ctrl.load_A = 1'b1;
                w_ctrl.load_B = 1'b1;
            end
            ST_EVAL: begin
                w_busy = 1'b1;
`ifdef MULT_EARLY_SKIP_EN
                if (!w_is_op) begin
                    w_ctrl.shift_HQ_LQ_Q_1 = 1'b1;
                end else begin
                    w_ctrl.load_add = 1'b1;
                    w_ctrl.add_sub  = (Q_LSB == BOOTH_ADD);
                end
`else
                w_ctrl.load_add = w_is_op;
                w_ctrl.add_sub  = (Q_LSB == BOOTH_ADD);
`endif
            end
            ST_SHIFT: begin
                w_busy                 = 1'b1;
                w_ctrl.shift_HQ_LQ_Q_1 = 1'b1;
            end
            ST_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: begin
                w_ctrl  = CTRL_NONE;
            end
        endcase
    end

    assign mult_control = w_ctrl;
    assign ready        = w_ready;
    assign busy         = w_busy;
    assign done         = w_done;

endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Bench for mult_booth_ctrl: vector table, directed corner sequences and
// random start/Q_LSB traffic against a behavioural model.
module tb_mult_booth_ctrl;
    import mult_pkg::*;

    localparam int N = 8;
`ifdef MULT_EARLY_SKIP_EN
    localparam int EXP_DONE_00 = N + 2;
`else
    localparam int EXP_DONE_00 = 2 * N + 2;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    q;
    mult_control_t ctl;
    logic          ready;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;
    logic [7:0] obs;

    // Model state: m_t = cycles since accepted start (0 = idle).
    int m_t  = 0;
    int m_k  = 0;
    int m_sh = 0;

    typedef struct {
        logic       st;
        logic [1:0] qq;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [21];

    mult_booth_ctrl #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .Q_LSB        (q),
        .mult_control (ctl),
        .ready        (ready),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Expected {ready,busy,done,load_A,load_B,load_add,shift,add_sub}.
    task automatic model_step(input logic st, input logic [1:0] qq, output logic [7:0] e);
        logic op;
        logic [7:0] ev;
        op = (qq == 2'b01) || (qq == 2'b10);
        ev = {3'b010, 2'b00, op, 1'b0, (qq == 2'b01)};
        if (m_t == 0) begin
            e = 8'b100_00000;
            if (st) begin
                m_t = 1; m_k = 0; m_sh = 0;
            end
        end else if (m_t == 1) begin
            e = 8'b010_11000;
            m_t = 2;
        end else begin
`ifdef MULT_EARLY_SKIP_EN
            if (m_t == 2) begin
                if (m_sh == 0 && op) begin
                    e = ev;
                    m_sh = 1;
                end else begin
                    e = 8'b010_00010;
                    m_sh = 0;
                    m_k++;
                    if (m_k == N) m_t = 3;
                end
            end else begin
                e = 8'b011_00000;
                m_t = 0;
            end
`else
            if (m_t <= 2 * N + 1) begin
                e = (m_t % 2 == 0) ? ev : 8'b010_00010;
                m_t++;
            end else begin
                e = 8'b011_00000;
                m_t = 0;
            end
`endif
        end
    endtask

    task automatic cyc(input logic st, input logic [1:0] qq, input string nm);
        logic [7:0] e;
        @(negedge clk);
        start = st;
        q     = qq;
        #1;
        obs = {ready, busy, done, ctl};
        model_step(st, qq, e);
        chk(nm, obs, e);
        total++;
        if (ctl.shift_HQ_LQ_Q_1 && (ctl.load_A || ctl.load_B || ctl.load_add)) begin
            bad++;
            $display("FAIL exclusive: ctl=%b", ctl);
        end
        $display("cyc %s st=%b q=%b out=%b", nm, st, qq, obs);
        @(posedge clk);
    endtask

    initial begin
        int loads[$];
        int n_shift;
        int n_ladd;
        int done_at;

        rst_n = 1'b0;
        start = 1'b0;
        q     = 2'b00;
        #3;
        chk("reset", {ready, busy, done, ctl}, 8'b100_00000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // One full operation with Q_LSB=01 (identical in both builds).
        for (int i = 0; i < 21; i++) begin
            tbl[i].st = (i == 0);
            tbl[i].qq = 2'b01;
            if (i == 0 || i >= 19)  tbl[i].exp = 8'b100_00000;
            else if (i == 1)        tbl[i].exp = 8'b010_11000;
            else if (i == 18)       tbl[i].exp = 8'b011_00000;
            else if (i % 2 == 0)    tbl[i].exp = 8'b010_00101;
            else                    tbl[i].exp = 8'b010_00010;
        end
        for (int i = 0; i < 21; i++) begin
            cyc(tbl[i].st, tbl[i].qq, "tbl_model");
            chk($sformatf("tbl[%0d]", i), obs, tbl[i].exp);
        end

        // Subtract pattern: EVAL must assert load_add with add_sub=0.
        cyc(1'b1, 2'b10, "sub");
        for (int i = 1; i < 21; i++) cyc(1'b0, 2'b10, "sub");

        // Q_LSB=00: shift count, no load_add, done timing.
        n_shift = 0; n_ladd = 0; done_at = -1;
        cyc(1'b1, 2'b00, "nop");
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 2'b00, "nop");
            if (obs[1]) n_shift++;
            if (obs[2]) n_ladd++;
            if (obs[5]) done_at = i;
        end
        chk_int("nop_shifts", n_shift, N);
        chk_int("nop_load_add", n_ladd, 0);
        chk_int("nop_done_cycle", done_at, EXP_DONE_00);

        // Start held high: only LOADs at cycles 1 and 20.
        for (int i = 0; i < 38; i++) begin
            cyc(1'b1, 2'b01, "hold");
            if (obs[4]) loads.push_back(i);
        end
        chk_int("hold_loads", loads.size(), 2);
        if (loads.size() == 2) begin
            chk_int("hold_load0", loads[0], 1);
            chk_int("hold_load1", loads[1], 20);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b01, "hold_tail");

        // Async reset in the middle of cycle 7.
        cyc(1'b1, 2'b01, "rst_seq");
        for (int i = 1; i <= 6; i++) cyc(1'b0, 2'b01, "rst_seq");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {ready, busy, done, ctl}, 8'b100_00000);
        @(negedge clk);
        rst_n = 1'b1;
        m_t = 0; m_k = 0; m_sh = 0;
        cyc(1'b1, 2'b01, "post_rst_idle");
        cyc(1'b0, 2'b01, "post_rst_load");
        chk("post_rst_load", obs, 8'b010_11000);
        for (int i = 0; i < 20; i++) cyc(1'b0, 2'b01, "post_rst_drain");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), "rand");
        end
        for (int i = 0; i < 20; i++) cyc(1'b0, 2'($urandom_range(0, 3)), "rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
